// File: rtl/ps2_scan_decoder_pkg.sv
// ps2_pkg: shared decoder states, PS/2 code constants and the event record
package ps2_pkg;
  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;
  localparam logic [7:0] C_F0 = 8'hF0;
  localparam logic [7:0] C_E0 = 8'hE0;
  localparam logic [7:0] C_E1 = 8'hE1;
  localparam logic [7:0] C_12 = 8'h12;
  localparam logic [7:0] C_AA = 8'hAA;
  localparam logic [7:0] C_FA = 8'hFA;
  localparam logic [7:0] C_EE = 8'hEE;
  localparam logic [7:0] C_FE = 8'hFE;
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;
  function automatic evt_t mk_evt(input logic [7:0] c, input logic b, input logic e);
    return {c, b, e};
  endfunction
  // keyboard status/ack bytes and bus idle patterns are not key events
  function automatic logic is_noise(input logic [7:0] c);
    return c inside {C_AA, C_FA, C_EE, C_FE, 8'h00, 8'hFF};
  endfunction
endpackage

// File: rtl/ps2_scan_decoder_fifo.sv
// ps2_evt_fifo: synchronous event FIFO with valid/ready read side (used under PS2_EVT_FIFO_EN)
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk25,
  input  logic clr_n,
  input  logic wr,
  input  evt_t wdata,
  output logic full,
  output logic rd_valid,
  input  logic rd_ready,
  output evt_t rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  evt_t mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic rd, we;
  assign rd = rd_valid && rd_ready;
  assign we = wr && (!full || rd);
  assign full = cnt == CW'(DEPTH);
  assign rd_valid = cnt != '0;
  assign rdata = rd_valid ? mem[rp] : '0;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk25)
    if (!clr_n) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + CW'(we) - CW'(rd);
    end
  // storage needs no reset; empty entries are masked on the read side
  always_ff @(posedge clk25)
    if (we) mem[wp] <= wdata;
endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: debounces the PS/2 receiver byte and decodes make/break/extended events.
// Define PS2_EVT_FIFO_EN for a FIFO_DEPTH event FIFO; otherwise a single output register is used.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int STABLE_CYCLES = 5000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk25,
  input  logic        clr_n,
  input  logic [15:0] key,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_code,
  output logic        evt_break,
  output logic        evt_ext,
  output logic        overflow
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [7:0] s1, s2, lb;
  logic [CW-1:0] cnt;
  logic acc;
  state_t st;
  logic [2:0] skip;
  logic wr;
  evt_t wd;
  logic full;
  logic unused_hi;
  assign unused_hi = ^key[15:8];
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    $error("FIFO_DEPTH must be a power of two in 2..16");
  // synchronize the newest byte and accept it once it has held still long enough
  always_ff @(posedge clk25)
    if (!clr_n) begin
      s1 <= '0;
      s2 <= '0;
      lb <= '0;
      cnt <= '0;
      acc <= 1'b0;
    end else begin
      s1 <= key[7:0];
      s2 <= s1;
      acc <= (s2 == lb) && (cnt == CW'(STABLE_CYCLES - 1));
      if (s2 != lb) begin
        lb <= s2;
        cnt <= '0;
      end else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
    end
  // prefix decoder; one accepted byte per step, emits a registered write strobe
  always_ff @(posedge clk25)
    if (!clr_n) begin
      st <= S_IDLE;
      skip <= '0;
      wr <= 1'b0;
      wd <= '0;
    end else begin
      wr <= 1'b0;
      if (acc)
        case (st)
          S_IDLE:
            if (lb == C_F0) st <= S_BRK;
            else if (lb == C_E0) st <= S_EXT;
            else if (lb == C_E1) begin
              st <= S_PAUSE;
              skip <= 3'd7;
            end else if (!is_noise(lb)) begin
              wr <= 1'b1;
              wd <= mk_evt(lb, 1'b0, 1'b0);
            end
          S_BRK: begin
            st <= S_IDLE;
            wr <= 1'b1;
            wd <= mk_evt(lb, 1'b1, 1'b0);
          end
          S_EXT:
            if (lb == C_F0) st <= S_EXT_BRK;
            else begin
              st <= S_IDLE;
              wr <= lb != C_12;
              wd <= mk_evt(lb, 1'b0, 1'b1);
            end
          S_EXT_BRK: begin
            st <= S_IDLE;
            wr <= lb != C_12;
            wd <= mk_evt(lb, 1'b1, 1'b1);
          end
          S_PAUSE: begin
            skip <= skip - 3'd1;
            if (skip == 3'd1) begin
              st <= S_IDLE;
              wr <= 1'b1;
              wd <= mk_evt(C_E1, 1'b0, 1'b0);
            end
          end
          default: st <= S_IDLE;
        endcase
    end
`ifdef PS2_EVT_FIFO_EN
  evt_t rdt;
  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk25   (clk25),
    .clr_n   (clr_n),
    .wr      (wr),
    .wdata   (wd),
    .full    (full),
    .rd_valid(evt_valid),
    .rd_ready(evt_ready),
    .rdata   (rdt)
  );
  assign {evt_code, evt_break, evt_ext} = rdt;
`else
  evt_t ob;
  logic ov;
  // single holding register; a new event replaces the old one only when it is being taken
  always_ff @(posedge clk25)
    if (!clr_n) begin
      ov <= 1'b0;
      ob <= '0;
    end else if (wr && (!ov || evt_ready)) begin
      ov <= 1'b1;
      ob <= wd;
    end else if (evt_ready) ov <= 1'b0;
  assign full = ov;
  assign evt_valid = ov;
  assign {evt_code, evt_break, evt_ext} = ob;
`endif
  // sticky: an event arrived with no room and nothing leaving
  always_ff @(posedge clk25)
    if (!clr_n) overflow <= 1'b0;
    else if (wr && full && !(evt_valid && evt_ready)) overflow <= 1'b1;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed and random byte streams checked against a prefix-rule model
module tb_ps2_scan_decoder;
  localparam int S = 50;
  localparam int HOLD = S + 20;
`ifdef PS2_EVT_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic clk25 = 1'b0;
  logic clr_n;
  logic [15:0] key;
  logic evt_valid, evt_ready, evt_break, evt_ext, overflow;
  logic [7:0] evt_code;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  bit m_brk, m_ext, m_ovf;
  int m_pause, held;

  ps2_scan_decoder #(.STABLE_CYCLES(S), .FIFO_DEPTH(4)) dut (
    .clk25    (clk25),
    .clr_n    (clr_n),
    .key      (key),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_break(evt_break),
    .evt_ext  (evt_ext),
    .overflow (overflow)
  );

  always #20 clk25 = ~clk25;

  always @(negedge clk25)
    if (clr_n && evt_valid && evt_ready) got.push_back({evt_code, evt_break, evt_ext});

  task automatic cyc(int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic emit(logic [9:0] ev);
    if (evt_ready) exp_q.push_back(ev);
    else if (held < CAP) begin
      exp_q.push_back(ev);
      held++;
    end else m_ovf = 1'b1;
  endtask

  task automatic model_byte(logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) emit({8'hE1, 2'b00});
    end else if (m_brk || m_ext) begin
      if (m_ext && !m_brk && b == 8'hF0) m_brk = 1'b1;
      else begin
        if (!(m_ext && b == 8'h12)) emit({b, m_brk, m_ext});
        m_brk = 1'b0;
        m_ext = 1'b0;
      end
    end else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hE1) m_pause = 7;
    else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) emit({b, 2'b00});
  endtask

  task automatic send(logic [7:0] b);
    key = {key[7:0], ~b};
    cyc(5);
    key[7:0] = b;
    cyc(HOLD);
    model_byte(b);
  endtask

  task automatic check_evts(string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(int n);
    clr_n = 1'b0;
    cyc(n);
    clr_n = 1'b1;
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_pause = 0;
    m_ovf = 1'b0;
    held = 0;
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int r;
    key = '0;
    evt_ready = 1'b1;
    do_reset(3);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_break", 32'(evt_break), 0);
    chk("rst_ext", 32'(evt_ext), 0);
    chk("rst_ovf", 32'(overflow), 0);
    cyc(HOLD);
    check_evts("idle_00");
    send(8'h1C);
    check_evts("make_1c");
    send(8'hF0);
    check_evts("f0_silent");
    send(8'h1C);
    check_evts("break_1c");
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_evts("ext_break_75");
    send(8'hE0);
    send(8'h12);
    check_evts("fake_shift");
    key = {key[7:0], 8'h1C};
    cyc(20);
    key = {key[7:0], 8'h3A};
    cyc(20);
    key = {key[7:0], 8'h1C};
    cyc(HOLD);
    model_byte(8'h1C);
    check_evts("glitch");
    send(8'h1C);
    send(8'h1C);
    check_evts("typematic");
    evt_ready = 1'b0;
    send(8'h15);
    send(8'h16);
    send(8'h1D);
    send(8'h1E);
    send(8'h26);
    chk("full_ovf", 32'(overflow), 32'(m_ovf));
    chk("full_valid", 32'(evt_valid), 1);
    chk("full_head", 32'(evt_code), 32'(exp_q[0][9:2]));
    evt_ready = 1'b1;
    cyc(10);
    check_evts("drain");
    chk("ovf_sticky", 32'(overflow), 1);
    send(8'hF0);
    do_reset(1);
    chk("rst_ovf_clr", 32'(overflow), 0);
    send(8'h1C);
    check_evts("rst_discard");
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    check_evts("pause");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = r == 0 ? 8'hF0 : r == 1 ? 8'hE0 : r == 2 ? 8'h12 : r == 3 ? 8'hAA :
          r == 4 ? 8'hE1 : r == 5 ? 8'h00 : 8'($urandom_range(1, 8'h83));
      send(b);
      check_evts("random");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 5000: clk25 cycles the key low byte must hold unchanged before it is accepted (200 us; longer than the slowest PS/2 bit period).
REQ-002 Parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-003 Port clk25, input, 1: sole clock, 25 MHz.
REQ-004 Port clr_n, input, 1: reset; one clock; synchronous, active-low.
REQ-005 Port key, input, 16: receiver scan-code bus; [7:0] newest byte, [15:8] previous byte; asynchronous to clk25.
REQ-006 Port evt_valid, output, 1: an event is presented.
REQ-007 Port evt_ready, input, 1: consumer accepts the event.
REQ-008 Port evt_code, output, 8: scan code, without E0/F0 prefixes.
REQ-009 Port evt_break, output, 1: 1 = key release, 0 = key press.
REQ-010 Port evt_ext, output, 1: the code was E0-prefixed.
REQ-011 Port overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.

Function
REQ-012 key[7:0] SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-013 Any change of the synchronized byte SHALL reload the stability counter; the byte is accepted once, in the cycle the counter reaches STABLE_CYCLES with no further change.
REQ-014 Repeat of an identical code (typematic) SHALL be accepted again, because the intermediate shift values count as changes.
REQ-015 States: IDLE, BRK, EXT, EXT_BRK, PAUSE.
REQ-016 IDLE: F0->BRK; E0->EXT; E1->PAUSE with skip counter=7; AA/FA/EE/FE/00/FF->dropped, stay IDLE; any other code->emit {code, break=0, ext=0}, stay IDLE.
REQ-017 BRK: any code->emit {code, 1, 0}, go to IDLE.
REQ-018 EXT: F0->EXT_BRK; 12 (fake shift)->drop, go to IDLE; any other code->emit {code, 0, 1}, go to IDLE.
REQ-019 EXT_BRK: 12->drop, go to IDLE; any other code->emit {code, 1, 1}, go to IDLE.
REQ-020 PAUSE: each accepted byte decrements the skip counter; at 0, emit {E1, 0, 0} and go to IDLE.
REQ-021 Emit latency SHALL be 1 cycle from acceptance to FIFO write; with the FIFO empty, evt_valid SHALL rise 2 cycles after acceptance.
REQ-022 Transfer occurs when evt_valid&&evt_ready are both high; outputs SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-023 Write and read in the same cycle with the FIFO full SHALL both succeed; no overflow.
REQ-024 Write with the FIFO full and no read SHALL drop the new event and set overflow; overflow clears only on reset.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-026 On clr_n=0 at a clk25 edge: state=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, overflow=0, stability counter=0, synchronizer and last-byte registers = current key is not used; registers = 8'h00.
REQ-027 Reset during a partial sequence (BRK/EXT/PAUSE) SHALL discard the sequence; the next accepted byte is decoded from IDLE.

Configuration
REQ-028 Macro PS2_EVT_FIFO_EN: defined -> FIFO of FIFO_DEPTH as above; undefined -> single output register, where a write while evt_valid=1 and evt_ready=0 drops the event and sets overflow, and evt_valid latency stays 2 cycles.

Structure
REQ-029 A shared package ps2_pkg SHALL hold the state enum, the constants for codes F0/E0/E1/12/AA/FA/EE/FE, and the event struct {code[7:0], brk, ext}.
REQ-030 Sub-module ps2_evt_fifo (synchronous FIFO, valid/ready output) SHALL be instantiated only under PS2_EVT_FIFO_EN.

Verification
REQ-031 key[7:0]=1C held for 6000 cycles, evt_ready=1 -> one event {1C, 0, 0}.
REQ-032 Bytes F0, 1C, each stable for 6000 cycles -> one event {1C, 1, 0}; nothing emitted for F0.
REQ-033 Bytes E0, F0, 75 -> {75, 1, 1}; bytes E0, 12 -> no event.
REQ-034 Byte 1C glitching to 3A for 2000 cycles, then back to 1C for 6000 cycles -> exactly one event {1C, 0, 0}; the 3A is never accepted.
REQ-035 evt_ready=0, 5 make codes with FIFO_DEPTH=4 -> 4 events held and overflow=1; with evt_ready=1 they drain in order.
REQ-036 clr_n=0 after F0, then byte 1C -> {1C, 0, 0}; E1 followed by 7 bytes -> one event {E1, 0, 0}.
